selector_mod: RTL and testbench

Switch-conditioning and mode-select stage at the front of the DE10-Lite shift demo. It synchronizes and debounces the two raw slide switches and runs a small mode FSM. The FSM drives the `bLED` / `bHEX` enables consumed by the tick counter, the LED chaser and the HEX controller. It also emits a one-cycle `change_o` pulse so downstream stages can restart cleanly on a mode change.

---
 rtl/selector_mod.sv | 105 ++++++++++
 tb/tb_selector_mod.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/selector_mod.sv
// selector_mod: synchronizes and debounces the two slide switches and runs
// the mode FSM that drives the LED-chaser and HEX-controller enables.
module selector_mod #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned EXCLUSIVE       = 0
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       sw0,
    input  logic       sw1,
    output logic       bLED,
    output logic       bHEX,
    output logic [1:0] mode_o,
    output logic       change_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_LED  = 2'b01,
        MODE_HEX  = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    // Bit 0 is the LED channel (sw0), bit 1 the HEX channel (sw1).
    logic [1:0]       sw_raw;
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       stable;
    logic [1:0]       stable_d;
    logic [CNT_W-1:0] cnt [2];
    logic [1:0]       rise_c;
    logic [1:0]       fall_c;
    mode_t            mode_q;
    mode_t            mode_nxt_c;

    assign sw_raw = {sw1, sw0};

    // Two-flop synchronizer plus per-channel debounce counter and edge history.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= sw_raw;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Accept pulses: one cycle each, straight off the stable/history flops.
    assign rise_c = stable & ~stable_d;
    assign fall_c = ~stable & stable_d;

    // Next mode: direct switch image, or last-activated-wins when exclusive.
    always_comb begin
        mode_nxt_c = mode_q;
        if (EXCLUSIVE == 0) begin
            mode_nxt_c = mode_t'(stable);
        end else begin
            if (rise_c[1]) begin
                mode_nxt_c = MODE_HEX;
            end else if (rise_c[0]) begin
                mode_nxt_c = MODE_LED;
            end else if (mode_q == MODE_LED && fall_c[0]) begin
                mode_nxt_c = stable[1] ? MODE_HEX : MODE_OFF;
            end else if (mode_q == MODE_HEX && fall_c[1]) begin
                mode_nxt_c = stable[0] ? MODE_LED : MODE_OFF;
            end
        end
    end

    // Mode register with a change strobe coincident with the new mode.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q   <= MODE_OFF;
            change_o <= 1'b0;
        end else begin
            mode_q   <= mode_nxt_c;
            change_o <= (mode_nxt_c != mode_q);
        end
    end

    assign mode_o = mode_q;
    assign bLED   = mode_q[0];
    assign bHEX   = mode_q[1];

endmodule

// File: tb/tb_selector_mod.sv
// tb_selector_mod: directed checks of two selector_mod instances
// (shared/non-exclusive and exclusive) with DEBOUNCE_CYCLES = 4.
module tb_selector_mod;

    logic       clk;
    logic       reset;
    logic       sw0;
    logic       sw1;
    logic       led0, hex0, c0;
    logic [1:0] m0;
    logic       led1, hex1, c1;
    logic [1:0] m1;

    int checks = 0;
    int passed = 0;

    selector_mod #(.DEBOUNCE_CYCLES(4), .EXCLUSIVE(0)) dut0 (
        .clk_i(clk), .reset_i(reset), .sw0(sw0), .sw1(sw1),
        .bLED(led0), .bHEX(hex0), .mode_o(m0), .change_o(c0)
    );

    selector_mod #(.DEBOUNCE_CYCLES(4), .EXCLUSIVE(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .sw0(sw0), .sw1(sw1),
        .bLED(led1), .bHEX(hex1), .mode_o(m1), .change_o(c1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge, then settle; inputs changed after this land at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sw0   = 1'b0;
        sw1   = 1'b0;
        repeat (3) tick();
        checks++; if (m0 !== 2'b00) $display("FAIL reset_mode0 got=%b exp=00", m0); else passed++;
        checks++; if (m1 !== 2'b00) $display("FAIL reset_mode1 got=%b exp=00", m1); else passed++;
        checks++; if (c0 !== 1'b0) $display("FAIL reset_change0 got=%b exp=0", c0); else passed++;
        checks++; if (c1 !== 1'b0) $display("FAIL reset_change1 got=%b exp=0", c1); else passed++;
        checks++; if ({led0, hex0} !== 2'b00) $display("FAIL reset_en0 got=%b exp=00", {led0, hex0}); else passed++;
        checks++; if ({led1, hex1} !== 2'b00) $display("FAIL reset_en1 got=%b exp=00", {led1, hex1}); else passed++;
    endtask

    task automatic test_power_on_sw0();
        logic [1:0] exp_m;
        logic       exp_c;
        reset = 1'b0;
        sw0   = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            exp_m = (e >= 7) ? 2'b01 : 2'b00;
            exp_c = (e == 7);
            checks++; if (m0 !== exp_m) $display("FAIL pwr_mode0 edge=%0d got=%b exp=%b", e, m0, exp_m); else passed++;
            checks++; if (c0 !== exp_c) $display("FAIL pwr_change0 edge=%0d got=%b exp=%b", e, c0, exp_c); else passed++;
            if (e == 7) begin
                checks++; if (led0 !== 1'b1 || hex0 !== 1'b0) $display("FAIL pwr_en0 got=%b%b exp=10", led0, hex0); else passed++;
                checks++; if (m1 !== 2'b01 || c1 !== 1'b1) $display("FAIL pwr_dut1 got=%b/%b exp=01/1", m1, c1); else passed++;
            end
        end
        sw0 = 1'b0;
        repeat (10) tick();
        checks++; if (m0 !== 2'b00 || m1 !== 2'b00) $display("FAIL pwr_release got=%b/%b exp=00/00", m0, m1); else passed++;
    endtask

    task automatic test_glitch();
        int bad;
        // 3-cycle pulse must be rejected entirely.
        bad = 0;
        sw1 = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            if (e == 4) sw1 = 1'b0;
            tick();
            if (m0 !== 2'b00 || m1 !== 2'b00 || c0 !== 1'b0 || c1 !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL glitch3_quiet bad_edges=%0d exp=0", bad); else passed++;
        // 4-cycle pulse is accepted; fall (first sampled at edge 5) is accepted at edge 11.
        sw1 = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) sw1 = 1'b0;
            tick();
            if (e == 6) begin
                checks++; if (m0 !== 2'b00 || m1 !== 2'b00) $display("FAIL glitch4_early got=%b/%b exp=00/00", m0, m1); else passed++;
            end
            if (e == 7) begin
                checks++; if (m0 !== 2'b10 || c0 !== 1'b1) $display("FAIL glitch4_rise0 got=%b/%b exp=10/1", m0, c0); else passed++;
                checks++; if (m1 !== 2'b10 || c1 !== 1'b1) $display("FAIL glitch4_rise1 got=%b/%b exp=10/1", m1, c1); else passed++;
            end
            if (e == 8) begin
                checks++; if (c0 !== 1'b0 || c1 !== 1'b0) $display("FAIL glitch4_pulse_width got=%b/%b exp=0/0", c0, c1); else passed++;
            end
            if (e == 10) begin
                checks++; if (m0 !== 2'b10 || m1 !== 2'b10) $display("FAIL glitch4_hold got=%b/%b exp=10/10", m0, m1); else passed++;
            end
            if (e == 11) begin
                checks++; if (m0 !== 2'b00 || c0 !== 1'b1) $display("FAIL glitch4_fall0 got=%b/%b exp=00/1", m0, c0); else passed++;
                checks++; if (m1 !== 2'b00 || c1 !== 1'b1) $display("FAIL glitch4_fall1 got=%b/%b exp=00/1", m1, c1); else passed++;
            end
        end
    endtask

    task automatic test_mode_sequence();
        // {sw1, sw0} per step, expected shared-mode and exclusive-mode results.
        logic [1:0] sw_tab [6] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00};
        logic [1:0] ex0    [6] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b11, 2'b00};
        logic [1:0] ex1    [6] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
        logic [1:0] prev0;
        logic [1:0] prev1;
        int         pulses0;
        int         pulses1;
        prev0 = 2'b00;
        prev1 = 2'b00;
        for (int s = 0; s < 6; s++) begin
            pulses0 = 0;
            pulses1 = 0;
            {sw1, sw0} = sw_tab[s];
            for (int e = 1; e <= 10; e++) begin
                tick();
                if (c0 === 1'b1) pulses0++;
                if (c1 === 1'b1) pulses1++;
                if (e == 6) begin
                    checks++; if (m0 !== prev0 || m1 !== prev1) $display("FAIL seq_early step=%0d got=%b/%b exp=%b/%b", s, m0, m1, prev0, prev1); else passed++;
                end
                if (e == 7) begin
                    checks++; if (m0 !== ex0[s] || c0 !== 1'b1) $display("FAIL seq_dut0 step=%0d got=%b/%b exp=%b/1", s, m0, c0, ex0[s]); else passed++;
                    checks++; if (m1 !== ex1[s] || c1 !== 1'b1) $display("FAIL seq_dut1 step=%0d got=%b/%b exp=%b/1", s, m1, c1, ex1[s]); else passed++;
                    checks++; if ({hex0, led0} !== ex0[s]) $display("FAIL seq_en0 step=%0d got=%b exp=%b", s, {hex0, led0}, ex0[s]); else passed++;
                    checks++; if ({hex1, led1} !== ex1[s]) $display("FAIL seq_en1 step=%0d got=%b exp=%b", s, {hex1, led1}, ex1[s]); else passed++;
                end
            end
            checks++; if (pulses0 !== 1 || pulses1 !== 1) $display("FAIL seq_pulses step=%0d got=%0d/%0d exp=1/1", s, pulses0, pulses1); else passed++;
            prev0 = ex0[s];
            prev1 = ex1[s];
        end
    endtask

    task automatic test_toggle();
        int pulses;
        pulses = 0;
        for (int e = 1; e <= 32; e++) begin
            sw0 = (e <= 20) ? (((e - 1) / 2) % 2 == 0) : 1'b1;
            tick();
            if (c0 === 1'b1) pulses++;
            if (e == 26) begin
                checks++; if (m0 !== 2'b00) $display("FAIL toggle_early got=%b exp=00", m0); else passed++;
            end
            if (e == 27) begin
                checks++; if (m0 !== 2'b01 || c0 !== 1'b1) $display("FAIL toggle_accept got=%b/%b exp=01/1", m0, c0); else passed++;
                checks++; if (m1 !== 2'b01) $display("FAIL toggle_dut1 got=%b exp=01", m1); else passed++;
            end
        end
        checks++; if (pulses !== 1) $display("FAIL toggle_pulses got=%0d exp=1", pulses); else passed++;
        sw0 = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_debounce();
        int bad;
        bad = 0;
        sw1 = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (m0 !== 2'b00 || c0 !== 1'b0 || m1 !== 2'b00) $display("FAIL midrst_during got=%b/%b/%b exp=00/0/00", m0, c0, m1); else passed++;
        reset = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            tick();
            if (r <= 6 && (m0 !== 2'b00 || m1 !== 2'b00 || c0 !== 1'b0)) bad++;
            if (r == 7) begin
                checks++; if (m0 !== 2'b10 || c0 !== 1'b1) $display("FAIL midrst_accept0 got=%b/%b exp=10/1", m0, c0); else passed++;
                checks++; if (m1 !== 2'b10 || c1 !== 1'b1) $display("FAIL midrst_accept1 got=%b/%b exp=10/1", m1, c1); else passed++;
            end
        end
        checks++; if (bad !== 0) $display("FAIL midrst_early bad_edges=%0d exp=0", bad); else passed++;
    endtask

    task automatic test_reset_dominates();
        // sw1 still high and mode is HEX; a one-cycle reset clears everything.
        reset = 1'b1;
        tick();
        checks++; if (m0 !== 2'b00 || c0 !== 1'b0 || hex0 !== 1'b0) $display("FAIL rstdom_clear got=%b/%b/%b exp=00/0/0", m0, c0, hex0); else passed++;
        reset = 1'b0;
        repeat (6) tick();
        checks++; if (m0 !== 2'b00) $display("FAIL rstdom_early got=%b exp=00", m0); else passed++;
        tick();
        checks++; if (m0 !== 2'b10 || c0 !== 1'b1 || hex0 !== 1'b1) $display("FAIL rstdom_reaccept got=%b/%b/%b exp=10/1/1", m0, c0, hex0); else passed++;
        sw1 = 1'b0;
        repeat (10) tick();
        checks++; if (m0 !== 2'b00 || m1 !== 2'b00) $display("FAIL rstdom_idle got=%b/%b exp=00/00", m0, m1); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        sw0   = 1'b0;
        sw1   = 1'b0;
        test_reset();
        test_power_on_sw0();
        test_glitch();
        test_mode_sequence();
        test_toggle();
        test_reset_mid_debounce();
        test_reset_dominates();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
